reg_scoreboard: RTL

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/dlx_pkg.sv | 25 ++
 rtl/sb_hazard_check.sv | 48 ++++
 rtl/reg_scoreboard.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dlx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dlx_pkg
//  Purpose  : Shared types and constants for the register scoreboard:
//             register index type, register count, scoreboard FSM states,
//             and a helper that turns a register index into a one-hot mask.
//  Revision : 1.0 - initial release
// ============================================================================
package dlx_pkg;

    localparam int NUM_REGS = 32;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sb_state_t;

    function automatic logic [NUM_REGS-1:0] idx_onehot(input reg_idx_t idx);
        return NUM_REGS'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_hazard_check.sv
`default_nettype none
// ============================================================================
//  Module   : sb_hazard_check
//  Purpose  : Combinational RAW/WAW hazard detection against the pending-
//             write vector. With REG_SCOREBOARD_FORWARD_EN defined, a register
//             being written back this cycle is treated as already free.
//  Ports    : i_busy              pending-write bit per register
//             i_rs1/i_rs2/i_rd    operand / destination register numbers
//             i_use_rs1/i_use_rs2 operand-use flags
//             i_writes_rd         destination-write flag
//             i_wb_valid/i_wb_rd  writeback in flight this cycle
//             o_hazard            1 when the instruction must stall
//  Config   : REG_SCOREBOARD_FORWARD_EN (same-cycle writeback bypass)
//  Revision : 1.0 - initial release
// ============================================================================
module sb_hazard_check
    import dlx_pkg::*;
(
    input  logic [NUM_REGS-1:0] i_busy,
    input  reg_idx_t            i_rs1,
    input  reg_idx_t            i_rs2,
    input  reg_idx_t            i_rd,
    input  logic                i_use_rs1,
    input  logic                i_use_rs2,
    input  logic                i_writes_rd,
    input  logic                i_wb_valid,
    input  reg_idx_t            i_wb_rd,
    output logic                o_hazard
);

    logic [NUM_REGS-1:0] w_eff_busy;

`ifdef REG_SCOREBOARD_FORWARD_EN
    // The retiring register's value is available on the bypass this cycle.
    assign w_eff_busy = i_wb_valid ? (i_busy & ~idx_onehot(i_wb_rd)) : i_busy;
`else
    logic w_unused_wb;
    assign w_unused_wb = i_wb_valid ^ (^i_wb_rd);
    assign w_eff_busy  = i_busy;
`endif

    // Register 0 is never marked busy, so rs checks need no r0 guard.
    assign o_hazard = (i_use_rs1 && w_eff_busy[i_rs1])
                   || (i_use_rs2 && w_eff_busy[i_rs2])
                   || (i_writes_rd && (i_rd != '0) && w_eff_busy[i_rd]);

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Purpose  : Register scoreboard tracking one pending-write bit per register.
//             Stalls issue on RAW/WAW hazards, clears bits on writeback, flags
//             spurious writebacks, and supports a flush that drains all
//             pending writes before pulsing flush_done.
//  Ports    : clk, reset            clock / synchronous active-high reset
//             issue_valid           decode presents an instruction
//             issue_rs1/rs2/rd      register numbers
//             use_rs1/use_rs2       operand-use flags
//             writes_rd             destination-write flag
//             issue_ready           instruction accepted (with issue_valid)
//             wb_valid/wb_rd        writeback retiring wb_rd
//             flush_req             request to drain pending writes
//             flush_done            one-cycle pulse when drain completes
//             busy                  pending-write vector
//             wb_err                sticky: writeback to a non-busy register
//  Config   : REG_SCOREBOARD_FORWARD_EN (same-cycle writeback bypass)
//  Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import dlx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        use_rs1,
    input  logic        use_rs2,
    input  logic        writes_rd,
    output logic        issue_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush_req,
    output logic        flush_done,
    output logic [31:0] busy,
    output logic        wb_err
);

    localparam logic [NUM_REGS-1:0] c_R0_MASK = NUM_REGS'(1);

    sb_state_t           r_state;
    sb_state_t           w_state_next;
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;
    logic [NUM_REGS-1:0] w_busy_after_wb;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic                r_flush_done;
    logic                w_flush_done_next;
    logic                r_wb_err;
    logic                w_hazard;
    logic                w_accept;

    sb_hazard_check u_hazard (
        .i_busy      (r_busy),
        .i_rs1       (issue_rs1),
        .i_rs2       (issue_rs2),
        .i_rd        (issue_rd),
        .i_use_rs1   (use_rs1),
        .i_use_rs2   (use_rs2),
        .i_writes_rd (writes_rd),
        .i_wb_valid  (wb_valid),
        .i_wb_rd     (wb_rd),
        .o_hazard    (w_hazard)
    );

    // The flush_req cycle itself must not accept an issue, so it gates ready.
    assign issue_ready = (r_state == RUN) && !w_hazard && !flush_req && !reset;
    assign w_accept    = issue_valid && issue_ready;

    assign w_set = (w_accept && writes_rd && (issue_rd != '0)) ? idx_onehot(issue_rd) : '0;
    assign w_clr = wb_valid ? idx_onehot(wb_rd) : '0;

    assign w_busy_after_wb = r_busy & ~w_clr;
    // Set is OR-ed after the clear so a same-register set wins.
    assign w_busy_next     = (w_busy_after_wb | w_set) & ~c_R0_MASK;

    always_comb begin
        w_state_next      = r_state;
        w_flush_done_next = 1'b0;
        case (r_state)
            RUN: begin
                if (flush_req) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                // No issue is accepted in DRAIN, so only writebacks matter.
                if (w_busy_after_wb == '0) begin
                    w_state_next      = RUN;
                    w_flush_done_next = 1'b1;
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_flush_done <= w_flush_done_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= '0;
            r_wb_err <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (wb_valid && !r_busy[wb_rd]) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign busy       = r_busy;
    assign flush_done = r_flush_done;
    assign wb_err     = r_wb_err;

endmodule
`default_nettype wire
